// File: rtl/code_set_detector.sv
// Debounced switch-code membership detector: 2-flop sync, stability filter,
// writable membership mask, follow/sticky LED, hit pulse and saturating hit counter.
module code_set_detector #(
   parameter int W                     = 4,
   parameter int STABLE_CYCLES         = 4,
   parameter int CNT_W                 = 8,
   parameter logic [(2**W)-1:0] MASK_INIT = 16'hD750
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     code_in,
   input  logic             mask_we,
   input  logic [W-1:0]     mask_addr,
   input  logic             mask_data,
   input  logic             sticky,
   input  logic             clr,
   output logic             led,
   output logic             hit_pulse,
   output logic [CNT_W-1:0] hit_count,
   output logic             stable
);

   // state    | meaning
   // S_IDLE     | no code accepted since reset
   // S_SETTLING | input changed after a lock; counting equal samples again
   // S_LOCKED   | accepted code held in code_q; waiting for an input change
   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLING,
      S_LOCKED
   } state_t;

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   state_t          state, state_n;
   logic [W-1:0]    sync1, sync;
   logic            primed;
   logic [CW-1:0]   cnt, cnt_n;
   logic [W-1:0]    code_q;
   logic            valid;
   logic            accept;
   logic            same;

   logic [(2**W)-1:0] mask;
   logic            member;
   logic            mreg;
   logic            hit;
   logic            led_n;

   // sync1 is the newest sample; comparing it against sync gives the change flag
   // one edge earlier than comparing sync against a further delayed copy.
   assign same = (sync1 == sync);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= '0;
         sync   <= '0;
         primed <= 1'b0;
         state  <= S_IDLE;
         cnt    <= '0;
         code_q <= '0;
         valid  <= 1'b0;
      end else begin
         sync1  <= code_in;
         sync   <= sync1;
         primed <= 1'b1;
         state  <= state_n;
         cnt    <= cnt_n;
         if (accept) begin
            code_q <= sync;
            valid  <= 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      case (state)
         S_IDLE, S_SETTLING: begin
            // sync1 holds reset value until the first edge; do not count it
            if (!primed) begin
               cnt_n = '0;
            end else begin
               cnt_n = same ? (cnt + CW'(1)) : CW'(1);
               if (cnt_n >= CW'(STABLE_CYCLES)) begin
                  accept  = 1'b1;
                  state_n = S_LOCKED;
               end
            end
         end
         S_LOCKED: begin
            if (!same) begin
               state_n = S_SETTLING;
               cnt_n   = CW'(1);
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   assign stable = (state == S_LOCKED);

   assign member = valid & mask[code_q];
   assign hit    = member & ~mreg;

   always_comb begin
      led_n = led;
      if (!sticky) begin
         led_n = member;
      end else if (member) begin
         led_n = 1'b1;
      end else if (clr) begin
         led_n = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask      <= MASK_INIT;
         mreg      <= 1'b0;
         led       <= 1'b0;
         hit_pulse <= 1'b0;
         hit_count <= '0;
      end else begin
         if (mask_we) begin
            mask[mask_addr] <= mask_data;
         end
         mreg      <= member;
         led       <= led_n;
         hit_pulse <= hit;
         if (clr) begin
            hit_count <= '0;
         end else if (hit && (hit_count != {CNT_W{1'b1}})) begin
            hit_count <= hit_count + CNT_W'(1);
         end
      end
   end

endmodule
